// File: rtl/rx_deframer_pkg.sv
// Shared types and helpers for the rx_deframer: FSM state, dibit phase rotation
// and the Hamming-weight function used by the sync correlator.
package rx_deframer_pkg;

  typedef enum logic {SEARCH = 1'b0, PAYLOAD = 1'b1} state_t;

  // One quarter-turn of the constellation: r(d) = {~d[0], d[1]}.
  function automatic logic [1:0] rot_dibit(input logic [1:0] d);
    return {~d[0], d[1]};
  endfunction

  function automatic logic [1:0] unrot_dibit(input logic [1:0] d);
    return {d[0], ~d[1]};
  endfunction

  function automatic logic [5:0] popcount32(input logic [31:0] w);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + 6'(w[i]);
    return n;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w, input logic [1:0] k);
    logic [31:0] r;
    r = w;
    for (int j = 0; j < 3; j++)
      if (2'(j) < k)
        for (int i = 0; i < 16; i++) r[2*i +: 2] = rot_dibit(r[2*i +: 2]);
    return r;
  endfunction

  function automatic logic [1:0] unrot_k(input logic [1:0] d, input logic [1:0] k);
    logic [1:0] r;
    r = d;
    for (int j = 0; j < 3; j++)
      if (2'(j) < k) r = unrot_dibit(r);
    return r;
  endfunction

endpackage

// File: rtl/rx_deframer_fifo.sv
// Synchronous FIFO with a registered output stage; total occupancy (memory plus
// output register) is capped at DEPTH, and a pop frees a slot in the same cycle.
module fifo_sync #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    mem_count;
  logic             pop, load, wr_en, bypass, mem_wr, mem_rd;

  assign full     = (mem_count + CW'(out_valid)) == CW'(DEPTH);
  assign empty    = !out_valid;
  assign in_ready = !full || out_ready;
  assign pop      = out_valid && out_ready;
  assign load     = !out_valid || pop;
  assign wr_en    = in_valid && in_ready;
  // An empty memory lets a write go straight into the output register.
  assign bypass   = wr_en && load && (mem_count == '0);
  assign mem_wr   = wr_en && !bypass;
  assign mem_rd   = load && (mem_count != '0);

  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (mem_wr) wr_ptr <= wr_ptr + 1'b1;
      if (mem_rd) rd_ptr <= rd_ptr + 1'b1;
      mem_count <= mem_count + CW'(mem_wr) - CW'(mem_rd);
      if (load) begin
        if (mem_rd)      out_data <= mem[rd_ptr];
        else if (bypass) out_data <= in_data;
        out_valid <= mem_rd || bypass;
      end
    end
  end

endmodule

// File: rtl/rx_deframer.sv
// Dibit-stream deframer: error-tolerant sync hunt, MSB-first payload packing into
// a FIFO-buffered byte stream. RX_DEFRAMER_PHASE_RESOLVE_EN adds 4-phase resolution.
import rx_deframer_pkg::*;

module rx_deframer #(
  parameter logic [31:0] SYNC_WORD     = 32'h1ACFFC1D,
  parameter int          MAX_ERRORS    = 2,
  parameter int          PAYLOAD_BYTES = 100,
  parameter int          FIFO_DEPTH    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [1:0]  in_data,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        locked,
  output logic [1:0]  rotation,
  output logic        overflow,
  output logic [15:0] frame_count
);

  state_t      state;
  logic [31:0] sr, sr_next;
  logic [1:0]  dibit_cnt;
  logic [11:0] byte_cnt;
  logic [5:0]  byte_sr;
  logic        push_valid, push_last;
  logic [7:0]  push_data;
  logic        match, last_byte;
  logic [1:0]  pay_dibit;
  logic        fifo_in_ready, fifo_full, fifo_empty, unused_flags;
  logic [8:0]  fifo_out;

`ifdef RX_DEFRAMER_PHASE_RESOLVE_EN
  logic [1:0] rot_q, match_k;
  assign rotation = rot_q;
`else
  assign rotation = 2'd0;
`endif

  assign last_byte = (byte_cnt == 12'(PAYLOAD_BYTES - 1));

  always_comb begin
    sr_next = {sr[29:0], in_data};
`ifdef RX_DEFRAMER_PHASE_RESOLVE_EN
    match   = 1'b0;
    match_k = 2'd0;
    // Descending scan so the lowest matching rotation wins.
    for (int k = 3; k >= 0; k--) begin
      if (popcount32(sr_next ^ rot_word(SYNC_WORD, 2'(k))) <= 6'(MAX_ERRORS)) begin
        match   = 1'b1;
        match_k = 2'(k);
      end
    end
    pay_dibit = unrot_k(in_data, rot_q);
`else
    match     = popcount32(sr_next ^ SYNC_WORD) <= 6'(MAX_ERRORS);
    pay_dibit = in_data;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SEARCH;
      sr          <= '0;
      dibit_cnt   <= '0;
      byte_cnt    <= '0;
      byte_sr     <= '0;
      locked      <= 1'b0;
      overflow    <= 1'b0;
      frame_count <= '0;
      push_valid  <= 1'b0;
      push_data   <= '0;
      push_last   <= 1'b0;
`ifdef RX_DEFRAMER_PHASE_RESOLVE_EN
      rot_q       <= 2'd0;
`endif
    end else begin
      push_valid <= 1'b0;
      // Dropped bytes still advance the counters so frame alignment survives.
      if (push_valid && !fifo_in_ready) overflow <= 1'b1;
      if (in_valid) begin
        case (state)
          SEARCH: begin
            sr <= sr_next;
            if (match) begin
              state     <= PAYLOAD;
              locked    <= 1'b1;
              dibit_cnt <= '0;
              byte_cnt  <= '0;
`ifdef RX_DEFRAMER_PHASE_RESOLVE_EN
              rot_q     <= match_k;
`endif
            end
          end
          PAYLOAD: begin
            dibit_cnt <= dibit_cnt + 1'b1;
            byte_sr   <= {byte_sr[3:0], pay_dibit};
            if (dibit_cnt == 2'd3) begin
              push_valid <= 1'b1;
              push_data  <= {byte_sr, pay_dibit};
              push_last  <= last_byte;
              if (last_byte) begin
                state       <= SEARCH;
                locked      <= 1'b0;
                frame_count <= frame_count + 1'b1;
                sr          <= '0;
                byte_cnt    <= '0;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  fifo_sync #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (push_valid),
    .in_data   ({push_last, push_data}),
    .in_ready  (fifo_in_ready),
    .out_valid (out_valid),
    .out_data  (fifo_out),
    .out_ready (out_ready),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_last     = fifo_out[8];
  assign out_data     = fifo_out[7:0];
  assign unused_flags = fifo_full ^ fifo_empty;

endmodule
